y86_mem_responder: RTL

// - Memory-side responder for the Y86-64 core's data/instruction memory port; the core is the initiator.
// - Accepts one 8-byte little-endian read or write at a time through a valid/ready request channel.
// - Replies on a valid/ready response channel after a programmable number of wait states.
// - Flags out-of-range accesses so the core can raise status ADR.

---
 rtl/y86_mem_pkg.sv | 17 +
 rtl/y86_byte_ram.sv | 39 +++
 rtl/y86_mem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86-64 memory port: FSM states, word size and
// the status codes the core raises for memory faults.
package y86_mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES = 8;

    // Y86-64 status codes; ADR is what the core reports on a bad address.
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_ADR = 4'h3;

endpackage

// File: rtl/y86_byte_ram.sv
// Byte-addressed memory with an 8-byte little-endian combinational read port
// and a synchronous whole-word write port.
module y86_byte_ram
    import y86_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int IW          = $clog2(DEPTH_BYTES) + 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    localparam int AB = $clog2(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_rd
            logic [IW:0] byte_addr;
            assign byte_addr = {1'b0, addr} + (IW + 1)'(gi);
            // Bytes past the end read as zero; the caller never uses them.
            assign rdata[gi*8 +: 8] = (byte_addr < (IW + 1)'(DEPTH_BYTES))
                                      ? mem[byte_addr[AB-1:0]] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                mem[AB'(addr + IW'(i))] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/y86_mem_responder.sv
// Memory-side responder for the Y86-64 core: one 8-byte access in flight,
// programmable wait states, and out-of-range detection for status ADR.
module y86_mem_responder
    import y86_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW          = 64,
    parameter int WAIT_CYC    = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [63:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [63:0]   rsp_rdata,
    output logic          rsp_error
);

    localparam int          IW        = $clog2(DEPTH_BYTES) + 1;
    localparam logic [AW:0] LIMIT     = (AW + 1)'(DEPTH_BYTES);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

    mem_state_t    state_reg;
    logic [3:0]    cnt_reg;
    logic          write_reg;
    logic [AW-1:0] addr_reg;
    logic [63:0]   wdata_reg;
    logic [3:0]    stat_reg;
    logic          req_ready_reg;
    logic          rsp_valid_reg;
    logic [63:0]   rsp_rdata_reg;
    logic          rsp_error_reg;

    logic          accept;
    logic          in_idle;
    logic [3:0]    req_stat;
    logic          cur_write;
    logic [AW-1:0] cur_addr;
    logic [63:0]   cur_wdata;
    logic [3:0]    cur_stat;
    logic          commit;
    logic          ram_we;
    logic [63:0]   ram_rdata;
    logic [63:0]   rsp_rdata_next;

    assign accept  = req_valid && req_ready_reg;
    assign in_idle = (state_reg == MEM_IDLE);

    // One extra bit keeps addresses near the top of the space from wrapping into range.
    assign req_stat = (({1'b0, req_addr} + (AW + 1)'(WORD_BYTES - 1)) >= LIMIT)
                      ? STAT_ADR : STAT_AOK;

    // With zero wait states the access commits straight from the request inputs.
    assign cur_write = in_idle ? req_write : write_reg;
    assign cur_addr  = in_idle ? req_addr  : addr_reg;
    assign cur_wdata = in_idle ? req_wdata : wdata_reg;
    assign cur_stat  = in_idle ? req_stat  : stat_reg;

    assign commit = (in_idle && accept && (WAIT_CYC == 0)) ||
                    ((state_reg == MEM_WAIT) && (cnt_reg == 4'd1));

    assign ram_we = RESET && commit && cur_write && (cur_stat != STAT_ADR);

    assign rsp_rdata_next = (cur_write || (cur_stat == STAT_ADR)) ? 64'h0 : ram_rdata;

    y86_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .IW          (IW)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (cur_addr[IW-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg     <= MEM_IDLE;
            cnt_reg       <= 4'd0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 64'h0;
            stat_reg      <= STAT_AOK;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 64'h0;
            rsp_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                MEM_IDLE: begin
                    if (accept) begin
                        write_reg     <= req_write;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        stat_reg      <= req_stat;
                        req_ready_reg <= 1'b0;
                        if (WAIT_CYC == 0) begin
                            state_reg     <= MEM_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_rdata_reg <= rsp_rdata_next;
                            rsp_error_reg <= (req_stat == STAT_ADR);
                        end else begin
                            state_reg <= MEM_WAIT;
                            cnt_reg   <= WAIT_INIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg     <= MEM_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= rsp_rdata_next;
                        rsp_error_reg <= (stat_reg == STAT_ADR);
                    end
                end
                MEM_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= MEM_IDLE;
                        req_ready_reg <= 1'b1;
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= 64'h0;
                        rsp_error_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= MEM_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_error = rsp_error_reg;

endmodule
